// File: rtl/parity_pkg.sv
// Shared types and sizes for the 4-bit odd-parity serial receiver.
// No logic of its own; imported by parity_rx and its bench.
// Holds the receiver state encoding and the data/error-counter widths.
package parity_pkg;

   localparam int DATA_BITS = 4;
   localparam int ERR_CNT_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

endpackage

// File: rtl/parity_sync2.sv
// Two-flop synchronizer for the asynchronous serial line, reset to idle-high.
// Latency: 2 cycles from input to output.
// No backpressure; samples every cycle.
module parity_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   // Two-stage capture; reset to 1 so a reset never looks like a start bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/parity_rx.sv
// Serial receiver for start + 4 data (LSB first) + odd parity + stop frames.
// Latency: word valid H+6C+1 cycles after the synchronized start edge (+2 for sync).
// Backpressure: holds word until out_ready; a frame finishing while full is dropped and flags overrun.
// Optional parity-error counter on err_cnt is built only when PARITY_RX_ERR_CNT_EN is defined.
module parity_rx
   import parity_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in,
   output logic [DATA_BITS-1:0] out,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   localparam int C     = CLKS_PER_BIT;
   localparam int H     = C / 2;
   localparam int CNT_W = (C > 2) ? $clog2(C) : 1;

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(H - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(C - 1);
   localparam logic [2:0]       BITS_LAST = 3'(DATA_BITS - 1);

   logic                 w_rxs;
   state_t               r_state;
   state_t               w_state_nxt;
   logic [CNT_W-1:0]     r_cnt;
   logic [2:0]           r_bit_cnt;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_par;
   logic                 w_cnt_clr;
   logic                 w_shift;
   logic                 w_par_smp;
   logic                 w_done;
   logic                 w_p_ok;
   logic                 w_load;
   logic                 w_drop;

   logic [DATA_BITS-1:0] r_out;
   logic                 r_out_valid;
   logic                 r_perr;
   logic                 r_ferr;
   logic                 r_overrun;

   parity_sync2 u_sync (
      .clk (clk),
      .rst (rst),
      .i_d (in),
      .o_q (w_rxs)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and sample strobes; the cycle counter restarts at every sample point.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_clr   = 1'b0;
      w_shift     = 1'b0;
      w_par_smp   = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         IDLE: begin
            w_cnt_clr = 1'b1;
            if (!w_rxs) begin
               w_state_nxt = START;
            end
         end
         START: begin
            if (r_cnt == HALF_LAST) begin
               w_cnt_clr   = 1'b1;
               w_state_nxt = w_rxs ? IDLE : DATA;
            end
         end
         DATA: begin
            if (r_cnt == BIT_LAST) begin
               w_cnt_clr = 1'b1;
               w_shift   = 1'b1;
               if (r_bit_cnt == BITS_LAST) begin
                  w_state_nxt = PARITY;
               end
            end
         end
         PARITY: begin
            if (r_cnt == BIT_LAST) begin
               w_cnt_clr   = 1'b1;
               w_par_smp   = 1'b1;
               w_state_nxt = STOP;
            end
         end
         STOP: begin
            if (r_cnt == BIT_LAST) begin
               w_cnt_clr   = 1'b1;
               w_done      = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_cnt_clr   = 1'b1;
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Cycle and bit counters; the bit counter only runs inside DATA.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt     <= '0;
         r_bit_cnt <= '0;
      end else begin
         r_cnt <= w_cnt_clr ? '0 : r_cnt + CNT_W'(1);
         if (r_state != DATA) begin
            r_bit_cnt <= '0;
         end else if (w_shift) begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
         end
      end
   end

   // Data shifter (first bit on the line ends up in bit 0) and parity capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_shift <= '0;
         r_par   <= 1'b0;
      end else begin
         if (w_shift) begin
            r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
         end
         if (w_par_smp) begin
            r_par <= w_rxs;
         end
      end
   end

   // Odd parity: data plus parity bit must carry an odd number of ones.
   assign w_p_ok = ^{r_shift, r_par};
   assign w_load = w_done && (!r_out_valid || out_ready);
   assign w_drop = w_done && !w_load;

   // Output word register with valid/ready hold and overrun pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out       <= '0;
         r_out_valid <= 1'b0;
         r_perr      <= 1'b0;
         r_ferr      <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_overrun <= w_drop;
         if (w_load) begin
            r_out       <= r_shift;
            r_perr      <= ~w_p_ok;
            r_ferr      <= ~w_rxs;
            r_out_valid <= 1'b1;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out        = r_out;
   assign out_valid  = r_out_valid;
   assign parity_err = r_perr;
   assign frame_err  = r_ferr;
   assign overrun    = r_overrun;

`ifdef PARITY_RX_ERR_CNT_EN
   logic [ERR_CNT_W-1:0] r_err_cnt;

   // Saturating count of delivered words that failed parity; dropped frames are not counted.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_err_cnt <= '0;
      end else if (w_load && !w_p_ok && (r_err_cnt != '1)) begin
         r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
      end
   end

   assign err_cnt = r_err_cnt;
`else
   assign err_cnt = '0;
`endif

endmodule

// File: doc/parity_rx.md
# parity_rx

Serial receiver and checker for the 4-bit odd-parity link. Accepts a UART-style frame on a single line: start bit, 4 data bits LSB first, one odd-parity bit, one stop bit. Presents the nibble with parity-error and framing-error flags on a valid/ready output port. It is the receive end for our 4-bit odd-parity generator, where a valid 5-bit data+parity word always holds an odd number of ones.

## Interface
- CLKS_PER_BIT, 4: clock cycles per serial bit; integer ≥ 2.
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in  input  1  serial line; idles high; asynchronous to clk.
- out  output  4  received data nibble; bit 0 is the first data bit on the line.
- out_valid  output  1  out and the flags are valid.
- out_ready  input  1  consumer accepts the current word.
- parity_err  output  1  the word failed odd parity; qualified by out_valid.
- frame_err  output  1  the stop bit sampled low; qualified by out_valid.
- overrun  output  1  one-cycle pulse when a completed frame is dropped.
- err_cnt  output  8  saturating count of parity errors; see Configuration.

## Operation
- Two-flop synchronizer on in; both flops reset to 1. All logic uses the synchronized value rxs.
- Let C = CLKS_PER_BIT and H = C/2 (integer division). The bit counter is 3 bits; the cycle counter is wide enough to hold C−1.
- FSM states and transitions:
  - IDLE: go to START when rxs = 0.
  - START: wait H cycles, then resample. If rxs = 1, treat it as a false start and return to IDLE. Otherwise go to DATA.
  - DATA: sample every C cycles, shifting bits in LSB first. Go to PARITY after 4 samples.
  - PARITY: sample once, after C cycles.
  - STOP: sample once, after C cycles, then return to IDLE in the same cycle.
- Check rule: p_ok = ^{data[3:0], parity_bit}, i.e. 1 when the total count of ones is odd. parity_err = ~p_ok.
- frame_err is set when the stop sample is 0. The data and flags are still delivered.
- Output register load at STOP completion:
  - If out_valid = 0, or out_ready = 1 in the same cycle, load out, parity_err and frame_err and set out_valid.
  - Otherwise keep the old word, discard the new one and pulse overrun.
- Handshake:
  - out_valid stays high and out and the flags stay stable until a cycle with out_ready = 1.
  - out_valid clears on the next edge unless a new frame loads in that same cycle.
- out_ready while out_valid = 0 has no effect.
- Reset mid-frame: FSM returns to IDLE, counters clear, out_valid drops. The remainder of the interrupted frame may be seen as a new start; this is acceptable.

## Timing
- Reset values: out = 0, out_valid = 0, parity_err = 0, frame_err = 0, overrun = 0, err_cnt = 0.
- in to rxs latency: 2 cycles.
- Let t0 be the first cycle with rxs = 0 in IDLE. Sample points:
  - start check at t0+H;
  - data bit i at t0+H+(i+1)·C, for i = 0..3;
  - parity at t0+H+5C;
  - stop at t0+H+6C.
- out_valid rises at t0+H+6C+1 (registered).
- Back-to-back frames: a start edge one cycle after the stop sample is detected.

## Configuration
- PARITY_RX_ERR_CNT_EN defined:
  - err_cnt increments by 1 on each frame loaded with parity_err = 1.
  - It saturates at 255 and clears only on rst.
  - Dropped (overrun) frames are not counted.
- Not defined: err_cnt is tied to 8'd0 and no counter logic is built.

## Structure
- Package parity_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - DATA_BITS = 4;
  - ERR_CNT_W = 8.
- Sub-module parity_sync2 is the two-flop synchronizer with reset value 1, instantiated once.

## Test plan
- C = 4; send data 4'b1011 with parity 0, stop 1, out_ready tied 1 → out = 4'hB, parity_err = 0, frame_err = 0, out_valid for 1 cycle at t0+27.
- Send data 4'b1011 with parity 1 → out = 4'hB, parity_err = 1; with the macro defined, err_cnt = 1.
- Drive in low for 1 cycle only → no out_valid; FSM back in IDLE by t0+3.
- Send data 4'h0, parity 1, stop 0 → out = 4'h0, parity_err = 0, frame_err = 1.
- Hold out_ready = 0 and send two valid frames, 4'h3 then 4'h5 → out stays 4'h3; overrun pulses once at the second stop; after out_ready rises, out_valid clears.
- With the macro defined, send 260 parity-bad frames → err_cnt = 255. Then assert rst mid-frame → all outputs return to 0 on the next edge.
